// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle: decode/execute/writeback fields in,
// stall/flush/forwarding controls and statistics out.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFID_rs1;
  logic [4:0]       IFID_rs2;
  logic             IFID_uses_rs2;
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_rd;
  logic [4:0]       IDEX_rs1;
  logic [4:0]       IDEX_rs2;
  logic             EXMEM_RegWrite;
  logic [4:0]       EXMEM_rd;
  logic             MEMWB_RegWrite;
  logic [4:0]       MEMWB_rd;
  logic             branch_taken;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEX_bubble;
  logic             IFID_flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // pipeline side
  modport master (
    output IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_MemRead, IDEX_rd, IDEX_rs1,
           IDEX_rs2, EXMEM_RegWrite, EXMEM_rd, MEMWB_RegWrite, MEMWB_rd,
           branch_taken,
    input  PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, ForwardA, ForwardB,
           stall_count, flush_count
  );

  // hazard unit side
  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_MemRead, IDEX_rd, IDEX_rs1,
           IDEX_rs2, EXMEM_RegWrite, EXMEM_rd, MEMWB_RegWrite, MEMWB_rd,
           branch_taken,
    output PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, ForwardA, ForwardB,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush window, operand
// forwarding select and saturating stall/flush statistics.
//
// state | meaning
// RUN   | normal issue; load-use stalls possible
// FLUSH | post-branch window; fcnt counts remaining flush cycles
module hazard_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hif
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_evt;

  // load-use detection against the instruction currently in decode
  always_comb begin
    lu = hif.IDEX_MemRead && (hif.IDEX_rd != 5'd0) &&
         ((hif.IDEX_rd == hif.IFID_rs1) ||
          (hif.IFID_uses_rs2 && (hif.IDEX_rd == hif.IFID_rs2)));
  end

  // next state and pipeline controls; a taken branch overrides everything
  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    stall_evt       = 1'b0;
    hif.PCWrite     = 1'b1;
    hif.IFIDWrite   = 1'b1;
    hif.IDEX_bubble = 1'b0;
    hif.IFID_flush  = 1'b0;
    if (hif.branch_taken) begin
      hif.IFID_flush  = 1'b1;
      hif.IDEX_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FCNT_LOAD;
      end else begin
        state_d = RUN;
        fcnt_d  = 4'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            hif.PCWrite     = 1'b0;
            hif.IFIDWrite   = 1'b0;
            hif.IDEX_bubble = 1'b1;
            stall_evt       = 1'b1;
          end
        end
        FLUSH: begin
          hif.IFID_flush  = 1'b1;
          hif.IDEX_bubble = 1'b1;
          if (fcnt_q <= 4'd1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = 4'd0;
        end
      endcase
    end
    // reset holds the pipeline frozen and flushed regardless of inputs
    if (reset) begin
      hif.PCWrite     = 1'b0;
      hif.IFIDWrite   = 1'b0;
      hif.IDEX_bubble = 1'b1;
      hif.IFID_flush  = 1'b1;
    end
  end

  // forwarding select: EX/MEM has priority over MEM/WB, x0 never forwards
  always_comb begin
    hif.ForwardA = 2'b00;
    hif.ForwardB = 2'b00;
    if (hif.EXMEM_RegWrite && hif.EXMEM_rd != 5'd0 && hif.EXMEM_rd == hif.IDEX_rs1)
      hif.ForwardA = 2'b10;
    else if (hif.MEMWB_RegWrite && hif.MEMWB_rd != 5'd0 && hif.MEMWB_rd == hif.IDEX_rs1)
      hif.ForwardA = 2'b01;
    if (hif.EXMEM_RegWrite && hif.EXMEM_rd != 5'd0 && hif.EXMEM_rd == hif.IDEX_rs2)
      hif.ForwardB = 2'b10;
    else if (hif.MEMWB_RegWrite && hif.MEMWB_rd != 5'd0 && hif.MEMWB_rd == hif.IDEX_rs2)
      hif.ForwardB = 2'b01;
    if (reset) begin
      hif.ForwardA = 2'b00;
      hif.ForwardB = 2'b00;
    end
  end

  // saturating statistics counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hif.branch_taken && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign hif.stall_count = stall_cnt_q;
  assign hif.flush_count = flush_cnt_q;

  // state, flush counter and statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) driven with identical stimulus.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(16)) if2 ();
  hazard_unit_if #(.CNT_W(4))  if3 ();

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut2 (.clk(clk), .reset(reset), .hif(if2));
  hazard_unit #(.FLUSH_CYCLES(3), .CNT_W(4))  dut3 (.clk(clk), .reset(reset), .hif(if3));

  // {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush}
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0010;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RST   = 4'b0011;

  typedef struct {
    string      tag;
    int         which;
    logic [7:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  function automatic logic [7:0] obs(input int which);
    if (which == 2)
      return {if2.PCWrite, if2.IFIDWrite, if2.IDEX_bubble, if2.IFID_flush, if2.ForwardA, if2.ForwardB};
    return {if3.PCWrite, if3.IFIDWrite, if3.IDEX_bubble, if3.IFID_flush, if3.ForwardA, if3.ForwardB};
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                        input logic mr, input logic [4:0] idrd, input logic [4:0] idrs1,
                        input logic [4:0] idrs2, input logic exw, input logic [4:0] exrd,
                        input logic mww, input logic [4:0] mwrd, input logic br);
    if2.IFID_rs1 = rs1;  if3.IFID_rs1 = rs1;
    if2.IFID_rs2 = rs2;  if3.IFID_rs2 = rs2;
    if2.IFID_uses_rs2 = uses2;  if3.IFID_uses_rs2 = uses2;
    if2.IDEX_MemRead = mr;  if3.IDEX_MemRead = mr;
    if2.IDEX_rd = idrd;  if3.IDEX_rd = idrd;
    if2.IDEX_rs1 = idrs1;  if3.IDEX_rs1 = idrs1;
    if2.IDEX_rs2 = idrs2;  if3.IDEX_rs2 = idrs2;
    if2.EXMEM_RegWrite = exw;  if3.EXMEM_RegWrite = exw;
    if2.EXMEM_rd = exrd;  if3.EXMEM_rd = exrd;
    if2.MEMWB_RegWrite = mww;  if3.MEMWB_RegWrite = mww;
    if2.MEMWB_rd = mwrd;  if3.MEMWB_rd = mwrd;
    if2.branch_taken = br;  if3.branch_taken = br;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one cycle: queue expectations, check combinational outputs mid-cycle,
  // then let the clock edge happen
  task automatic step(input string tag, input logic [3:0] e2, input logic [3:0] e3,
                      input logic [1:0] fa, input logic [1:0] fb);
    sb_t s;
    sbq.push_back('{tag, 2, {e2, fa, fb}});
    sbq.push_back('{tag, 3, {e3, fa, fb}});
    @(negedge clk);
    while (sbq.size() > 0) begin
      logic [7:0] o;
      s = sbq.pop_front();
      o = obs(s.which);
      n_cmp++;
      assert (o === s.exp) else begin
        n_fail++;
        $error("FAIL %s dut%0d: observed %b expected %b", s.tag, s.which, o, s.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    // reset with hazard-inducing junk on every input
    reset = 1'b1;
    set_in(5, 5, 1, 1, 5, 3, 3, 1, 3, 1, 3, 1);
    step("rst_hold", C_RST, C_RST, 2'b00, 2'b00);
    chk_cnt("rst_stall2", if2.stall_count, 16'd0);
    chk_cnt("rst_flush2", if2.flush_count, 16'd0);
    chk_cnt("rst_flush3", {12'd0, if3.flush_count}, 16'd0);
    reset = 1'b0;
    idle();
    step("idle", C_RUN, C_RUN, 2'b00, 2'b00);

    // load-use on rs1
    set_in(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs1", C_STALL, C_STALL, 2'b00, 2'b00);
    chk_cnt("stall_cnt_1_dut2", if2.stall_count, 16'd1);
    chk_cnt("stall_cnt_1_dut3", {12'd0, if3.stall_count}, 16'd1);

    // rs2 match ignored unless used, rd=0 never stalls
    set_in(6, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs2_unused", C_RUN, C_RUN, 2'b00, 2'b00);
    set_in(6, 5, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs2_used", C_STALL, C_STALL, 2'b00, 2'b00);
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rd0", C_RUN, C_RUN, 2'b00, 2'b00);
    chk_cnt("stall_cnt_2", if2.stall_count, 16'd2);

    // branch with load-use pending: lu suppressed, window length per instance
    set_in(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1);
    step("br_c0", C_FLUSH, C_FLUSH, 2'b00, 2'b00);
    set_in(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step("br_c1_lu_ignored", C_FLUSH, C_FLUSH, 2'b00, 2'b00);
    idle();
    step("br_c2", C_RUN, C_FLUSH, 2'b00, 2'b00);
    step("br_c3", C_RUN, C_RUN, 2'b00, 2'b00);
    chk_cnt("stall_cnt_after_br", if2.stall_count, 16'd2);
    chk_cnt("flush_cnt_1", if2.flush_count, 16'd1);

    // branch again on the second flush cycle restarts the window
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rebr_c0", C_FLUSH, C_FLUSH, 2'b00, 2'b00);
    step("rebr_c1", C_FLUSH, C_FLUSH, 2'b00, 2'b00);
    idle();
    step("rebr_c2", C_FLUSH, C_FLUSH, 2'b00, 2'b00);
    step("rebr_c3", C_RUN, C_FLUSH, 2'b00, 2'b00);
    step("rebr_c4", C_RUN, C_RUN, 2'b00, 2'b00);
    chk_cnt("flush_cnt_3_dut2", if2.flush_count, 16'd3);
    chk_cnt("flush_cnt_3_dut3", {12'd0, if3.flush_count}, 16'd3);

    // forwarding priority and x0 exclusion
    set_in(0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 7, 0);
    step("fwd_ex", C_RUN, C_RUN, 2'b10, 2'b00);
    set_in(0, 0, 0, 0, 0, 7, 7, 1, 7, 1, 7, 0);
    step("fwd_ex_ab", C_RUN, C_RUN, 2'b10, 2'b10);
    set_in(0, 0, 0, 0, 0, 7, 7, 0, 7, 1, 7, 0);
    step("fwd_wb", C_RUN, C_RUN, 2'b01, 2'b01);
    set_in(0, 0, 0, 0, 0, 7, 7, 1, 0, 1, 7, 0);
    step("fwd_ex_rd0", C_RUN, C_RUN, 2'b01, 2'b01);
    set_in(0, 0, 0, 0, 0, 7, 7, 1, 0, 1, 0, 0);
    step("fwd_none", C_RUN, C_RUN, 2'b00, 2'b00);
    // forwarding unaffected by a stall
    set_in(5, 0, 0, 1, 5, 7, 0, 1, 7, 0, 0, 0);
    step("fwd_during_stall", C_STALL, C_STALL, 2'b10, 2'b00);

    // 20 more stalls: 4-bit counter saturates at 15
    set_in(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sat_stall", C_STALL, C_STALL, 2'b00, 2'b00);
    chk_cnt("stall_sat_dut3", {12'd0, if3.stall_count}, 16'd15);
    chk_cnt("stall_cnt_dut2", if2.stall_count, 16'd23);

    // reset during a flush window
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("pre_rst_br", C_FLUSH, C_FLUSH, 2'b00, 2'b00);
    idle();
    reset = 1'b1;
    step("rst_mid_flush", C_RST, C_RST, 2'b00, 2'b00);
    chk_cnt("rst_mid_stall", {12'd0, if3.stall_count}, 16'd0);
    chk_cnt("rst_mid_flushc", if2.flush_count, 16'd0);
    reset = 1'b0;
    step("post_rst_run", C_RUN, C_RUN, 2'b00, 2'b00);
    set_in(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst_stall", C_STALL, C_STALL, 2'b00, 2'b00);
    chk_cnt("post_rst_stall_cnt", if2.stall_count, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
